// File: rtl/l1_dcache_pkg.sv
// Shared types and geometry for the direct-mapped L1 data cache.
// Also holds the byte-masked word merge used by the data array.
package l1_cache_types;

  localparam int S_INDEX  = 3;
  localparam int S_OFFSET = 5;
  localparam int S_TAG    = 32 - S_INDEX - S_OFFSET;
  localparam int NUM_SETS = 2 ** S_INDEX;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  typedef logic [255:0] cache_line_t;

  // Replace the enabled bytes of one 32-bit word inside a line.
  function automatic cache_line_t merge_word(input cache_line_t line,
                                             input logic [2:0]  word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wmask);
    cache_line_t r;
    r = line;
    for (int b = 0; b < 4; b++) begin
      if (wmask[b]) r[int'(word) * 32 + b * 8 +: 8] = wdata[b * 8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/l1_dcache_array.sv
// Flop-based tag/valid/dirty/data storage, read combinationally by index.
// A full-line fill takes priority over a masked word write to the same set.
module l1_dcache_array
  import l1_cache_types::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [S_INDEX-1:0] idx,
  input  logic               fill_en,
  input  cache_line_t        fill_line,
  input  logic [S_TAG-1:0]   fill_tag,
  input  logic               wr_en,
  input  logic [2:0]         wr_word,
  input  logic [31:0]        wr_data,
  input  logic [3:0]         wr_mask,
  output cache_line_t        rd_line,
  output logic [S_TAG-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [S_TAG-1:0]    tag_q  [NUM_SETS];
  cache_line_t         data_q [NUM_SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Payload needs no reset: every set is invalid until a fill rewrites it.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[idx] <= fill_line;
      tag_q[idx]  <= fill_tag;
    end else if (wr_en) begin
      data_q[idx] <= merge_word(data_q[idx], wr_word, wr_data, wr_mask);
    end
  end

  assign rd_line  = data_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back/write-allocate L1 data cache: hit logic, miss FSM
// and single-outstanding pmem port. Handshake: mem_resp completes a held
// request; pmem strobes stay up with stable address/data until pmem_resp.
module l1_dcache
  import l1_cache_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_addr,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_wmask,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output state_t       dbg_state
);

  state_t             state_q, state_d;
  logic [26:0]        miss_line_q;
  logic [26:0]        cur_line;
  logic [S_INDEX-1:0] idx;
  logic [S_TAG-1:0]   tag;
  logic               req, hit;
  logic               fill_en, wr_en;
  cache_line_t        rd_line;
  logic [S_TAG-1:0]   rd_tag;
  logic               rd_valid, rd_dirty;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^mem_addr[1:0];

  // While a miss is in flight the latched line address drives the array, so
  // the pmem transaction stays stable even if the pipeline drops the request.
  assign cur_line = (state_q == IDLE) ? mem_addr[31:5] : miss_line_q;
  assign idx      = cur_line[S_INDEX-1:0];
  assign tag      = cur_line[26:S_INDEX];
  assign req      = mem_read | mem_write;
  assign hit      = rd_valid && (rd_tag == tag);

  l1_dcache_array u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx),
    .fill_en   (fill_en),
    .fill_line (pmem_rdata),
    .fill_tag  (tag),
    .wr_en     (wr_en),
    .wr_word   (mem_addr[4:2]),
    .wr_data   (mem_wdata),
    .wr_mask   (mem_wmask),
    .rd_line   (rd_line),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      miss_line_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req && !hit) miss_line_q <= mem_addr[31:5];
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    fill_en      = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            wr_en    = mem_write;
          end else if (rd_valid && rd_dirty) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {rd_tag, idx, 5'b0};
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {tag, idx, 5'b0};
        if (pmem_resp) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pmem_wdata = rd_line;
  assign mem_rdata  = rd_line[int'(mem_addr[4:2]) * 32 +: 32];
  assign dbg_state  = state_q;

  a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst_n)
                                        !(mem_read && mem_write));

endmodule
